// File: rtl/mem_stage_ctrl.sv
// Pipeline memory stage: loads/stores, 32-bit PC and flags stack push/pop over a req/ack memory port.
// Optional MEM_TIMEOUT_EN: per-word ack timeout aborts the access and sets a sticky mem_err.
module mem_stage_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              MR,
    input  logic              MW,
    input  logic              WB,
    input  logic [2:0]        WB_Address,
    input  logic              JWSP,
    input  logic              Stack_PC,
    input  logic              Stack_Flags,
    input  logic [2:0]        Final_Flags,
    input  logic [31:0]       Data,
    input  logic [ADDR_W-1:0] Address,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall,
    output logic              wb_valid,
    output logic              wb_en,
    output logic [2:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              pc_restore,
    output logic [31:0]       pc_out,
    output logic              flags_restore,
    output logic [2:0]        flags_out,
    output logic              mem_err
);

    typedef enum logic [1:0] {IDLE, ACC_LO, ACC_HI} state_t;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mem_stage_ctrl: TIMEOUT must be at least 1");
    end

    state_t state, state_nxt;

    logic              l_mr, l_mw, l_wb, l_jwsp, l_spc, l_sfl;
    logic [2:0]        l_wba, l_flags;
    logic [31:0]       l_data;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] lo_word;

    logic is_rd, done, to_hit;

    // MR and MW together behave as a plain write
    assign is_rd = l_mr & ~l_mw;
    assign done  = mem_ack & (((state == ACC_LO) & ~l_spc) | (state == ACC_HI));
    assign stall = (state != IDLE);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] to_cnt;

    assign to_hit = (state != IDLE) & ~mem_ack & (to_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt  <= '0;
            mem_err <= 1'b0;
        end else if (state == IDLE || mem_ack) begin
            to_cnt <= '0;
        end else if (to_hit) begin
            to_cnt  <= '0;
            mem_err <= 1'b1;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign to_hit  = 1'b0;
    assign mem_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                if (in_valid && (MR || MW)) state_nxt = ACC_LO;
            end
            ACC_LO: begin
                mem_req  = 1'b1;
                mem_we   = l_mw;
                mem_addr = l_addr;
                if (l_sfl && !l_spc) mem_wdata = DATA_W'(l_flags);
                else                 mem_wdata = DATA_W'(l_data[15:0]);
                if (to_hit)       state_nxt = IDLE;
                else if (mem_ack) state_nxt = l_spc ? ACC_HI : IDLE;
            end
            ACC_HI: begin
                mem_req   = 1'b1;
                mem_we    = l_mw;
                mem_addr  = l_addr + ADDR_W'(1);
                mem_wdata = DATA_W'(l_data[31:16]);
                if (to_hit || mem_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l_mr          <= 1'b0;
            l_mw          <= 1'b0;
            l_wb          <= 1'b0;
            l_jwsp        <= 1'b0;
            l_spc         <= 1'b0;
            l_sfl         <= 1'b0;
            l_wba         <= '0;
            l_flags       <= '0;
            l_data        <= '0;
            l_addr        <= '0;
            lo_word       <= '0;
            wb_valid      <= 1'b0;
            wb_en         <= 1'b0;
            wb_addr       <= '0;
            wb_data       <= '0;
            pc_restore    <= 1'b0;
            pc_out        <= '0;
            flags_restore <= 1'b0;
            flags_out     <= '0;
        end else begin
            wb_valid      <= 1'b0;
            pc_restore    <= 1'b0;
            flags_restore <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (MR || MW) begin
                            l_mr    <= MR;
                            l_mw    <= MW;
                            l_wb    <= WB;
                            l_jwsp  <= JWSP;
                            l_spc   <= Stack_PC;
                            l_sfl   <= Stack_Flags;
                            l_wba   <= WB_Address;
                            l_flags <= Final_Flags;
                            l_data  <= Data;
                            l_addr  <= Address;
                        end else begin
                            wb_valid <= 1'b1;
                            wb_en    <= WB;
                            wb_addr  <= WB_Address;
                            wb_data  <= DATA_W'(Data[15:0]);
                        end
                    end
                end
                ACC_LO, ACC_HI: begin
                    if (to_hit) begin
                        wb_valid <= 1'b1;
                        wb_en    <= 1'b0;
                        wb_addr  <= l_wba;
                    end else if (mem_ack) begin
                        if (is_rd && l_spc) begin
                            if (state == ACC_LO) pc_out[15:0]  <= mem_rdata[15:0];
                            else                 pc_out[31:16] <= mem_rdata[15:0];
                        end
                        if (state == ACC_LO) lo_word <= mem_rdata;
                        if (done) begin
                            wb_valid <= 1'b1;
                            wb_en    <= l_wb;
                            wb_addr  <= l_wba;
                            // a PC pop returns its low word, captured one word earlier
                            if (is_rd) wb_data <= (state == ACC_HI) ? lo_word : mem_rdata;
                            else       wb_data <= DATA_W'(l_data[15:0]);
                            pc_restore <= is_rd & l_spc & l_jwsp;
                            if (is_rd && l_sfl) begin
                                flags_restore <= 1'b1;
                                flags_out     <= mem_rdata[2:0];
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: pass-through, load wait states, PC/flags push and pop, reset abort.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 0, MR = 0, MW = 0, WB = 0, JWSP = 0, Stack_PC = 0, Stack_Flags = 0;
    logic [2:0]  WB_Address = 0, Final_Flags = 0;
    logic [31:0] Data = 0, Address = 0;
    logic        mem_req, mem_we, mem_ack = 0, stall;
    logic [31:0] mem_addr;
    logic [15:0] mem_wdata, mem_rdata = 0, wb_data;
    logic        wb_valid, wb_en, pc_restore, flags_restore, mem_err;
    logic [2:0]  wb_addr, flags_out;
    logic [31:0] pc_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_stage_ctrl #(.ADDR_W(32), .DATA_W(16), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .MR(MR), .MW(MW), .WB(WB),
        .WB_Address(WB_Address), .JWSP(JWSP), .Stack_PC(Stack_PC), .Stack_Flags(Stack_Flags),
        .Final_Flags(Final_Flags), .Data(Data), .Address(Address),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall),
        .wb_valid(wb_valid), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .pc_restore(pc_restore), .pc_out(pc_out), .flags_restore(flags_restore),
        .flags_out(flags_out), .mem_err(mem_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid = 0; MR = 0; MW = 0; WB = 0; JWSP = 0; Stack_PC = 0; Stack_Flags = 0;
        WB_Address = 0; Final_Flags = 0; Data = 0; Address = 0;
    endtask

    task automatic issue(input logic mr, input logic mw, input logic spc, input logic sfl,
                         input logic jw, input logic [31:0] addr, input logic [31:0] dat);
        clear_inputs();
        in_valid = 1; MR = mr; MW = mw; Stack_PC = spc; Stack_Flags = sfl; JWSP = jw;
        Address = addr; Data = dat; WB = mr; WB_Address = 3'd2;
        tick();
        // upstream garbage while stalled must not disturb the latched access
        clear_inputs();
        Data = 32'hDEAD_BEEF; Address = 32'h1234_5678;
    endtask

    initial begin
        int stall_cycles;

        #3;
        chk("reset_req", {31'b0, mem_req}, 0);
        chk("reset_stall", {31'b0, stall}, 0);
        chk("reset_wbv", {31'b0, wb_valid}, 0);
        chk("reset_pc", pc_out, 0);
        @(negedge clk);
        rst = 0;
        tick();

        // pass-through
        in_valid = 1; WB = 1; WB_Address = 3'd5; Data = 32'h0000_1234;
        chk("pt_stall_pre", {31'b0, stall}, 0);
        tick();
        chk("pt_wbv", {31'b0, wb_valid}, 1);
        chk("pt_wben", {31'b0, wb_en}, 1);
        chk("pt_addr", {29'b0, wb_addr}, 5);
        chk("pt_data", {16'b0, wb_data}, 32'h1234);
        chk("pt_req", {31'b0, mem_req}, 0);
        clear_inputs();
        tick();
        chk("bubble_wbv", {31'b0, wb_valid}, 0);
        chk("bubble_hold", {16'b0, wb_data}, 32'h1234);

        // load with ack on the fifth request cycle
        issue(1, 0, 0, 0, 0, 32'h40, 0);
        stall_cycles = 0;
        for (int i = 0; i < 5; i++) begin
            if (stall) stall_cycles++;
            chk("ld_addr", mem_addr, 32'h40);
            chk("ld_req", {31'b0, mem_req}, 1);
            chk("ld_we", {31'b0, mem_we}, 0);
            chk("ld_nowbv", {31'b0, wb_valid}, 0);
            if (i == 4) begin mem_ack = 1; mem_rdata = 16'hBEEF; end
            tick();
        end
        mem_ack = 0; mem_rdata = 0;
        chk("ld_stall_cycles", stall_cycles, 5);
        chk("ld_wbv", {31'b0, wb_valid}, 1);
        chk("ld_data", {16'b0, wb_data}, 32'hBEEF);
        chk("ld_stall_done", {31'b0, stall}, 0);
        chk("ld_req_done", {31'b0, mem_req}, 0);

        // PC push, immediate acks
        issue(0, 1, 1, 0, 0, 32'h3FE, 32'h0001_0020);
        chk("push_lo_addr", mem_addr, 32'h3FE);
        chk("push_lo_data", {16'b0, mem_wdata}, 32'h0020);
        chk("push_we", {31'b0, mem_we}, 1);
        mem_ack = 1;
        tick();
        chk("push_hi_req", {31'b0, mem_req}, 1);
        chk("push_hi_addr", mem_addr, 32'h3FF);
        chk("push_hi_data", {16'b0, mem_wdata}, 32'h0001);
        chk("push_hi_nowbv", {31'b0, wb_valid}, 0);
        tick();
        mem_ack = 0;
        chk("push_wbv", {31'b0, wb_valid}, 1);
        chk("push_stall", {31'b0, stall}, 0);
        chk("push_norestore", {31'b0, pc_restore}, 0);

        // PC pop with JWSP across the top of the address space
        issue(1, 0, 1, 0, 1, 32'hFFFF_FFFF, 0);
        chk("pop_lo_addr", mem_addr, 32'hFFFF_FFFF);
        mem_ack = 1; mem_rdata = 16'h0020;
        tick();
        chk("pop_hi_addr_wrap", mem_addr, 32'h0);
        mem_rdata = 16'h0001;
        tick();
        mem_ack = 0; mem_rdata = 0;
        chk("pop_restore", {31'b0, pc_restore}, 1);
        chk("pop_pc", pc_out, 32'h0001_0020);
        chk("pop_wbv", {31'b0, wb_valid}, 1);
        tick();
        chk("pop_restore_pulse", {31'b0, pc_restore}, 0);
        chk("pop_wbv_pulse", {31'b0, wb_valid}, 0);

        // flags push then pop
        clear_inputs();
        in_valid = 1; MW = 1; Stack_Flags = 1; Final_Flags = 3'b110; Address = 32'h20;
        tick();
        clear_inputs();
        chk("fpush_data", {16'b0, mem_wdata}, 32'h0006);
        mem_ack = 1;
        tick();
        mem_ack = 0;
        chk("fpush_wbv", {31'b0, wb_valid}, 1);
        chk("fpush_norestore", {31'b0, flags_restore}, 0);
        issue(1, 0, 0, 1, 0, 32'h20, 0);
        mem_ack = 1; mem_rdata = 16'h0005;
        tick();
        mem_ack = 0; mem_rdata = 0;
        chk("fpop_restore", {31'b0, flags_restore}, 1);
        chk("fpop_flags", {29'b0, flags_out}, 32'h5);
        chk("fpop_nopc", {31'b0, pc_restore}, 0);
        tick();
        chk("fpop_pulse", {31'b0, flags_restore}, 0);

        // stray ack while idle
        mem_ack = 1;
        tick();
        mem_ack = 0;
        chk("stray_ack_stall", {31'b0, stall}, 0);
        chk("stray_ack_wbv", {31'b0, wb_valid}, 0);

        // reset during ACC_HI
        issue(0, 1, 1, 0, 0, 32'h100, 32'hAAAA_5555);
        mem_ack = 1;
        tick();
        mem_ack = 0;
        chk("rst_in_hi", {31'b0, mem_req}, 1);
        #2 rst = 1;
        #1;
        chk("rst_req_drop", {31'b0, mem_req}, 0);
        chk("rst_stall_drop", {31'b0, stall}, 0);
        chk("rst_wbv_drop", {31'b0, wb_valid}, 0);
        @(negedge clk);
        rst = 0;
        tick();
        chk("rst_after_stall", {31'b0, stall}, 0);
        chk("rst_after_wbv", {31'b0, wb_valid}, 0);
        tick();
        chk("rst_after_wbv2", {31'b0, wb_valid}, 0);

`ifdef MEM_TIMEOUT_EN
        clear_inputs();
        in_valid = 1; MR = 1; WB = 1; WB_Address = 3'd3; Address = 32'h50;
        tick();
        clear_inputs();
        for (int i = 0; i < 14; i++) begin
            chk("to_waiting", {31'b0, stall}, 1);
            tick();
        end
        chk("to_last_wait", {31'b0, stall}, 1);
        tick();
        chk("to_abort_stall", {31'b0, stall}, 0);
        chk("to_err", {31'b0, mem_err}, 1);
        chk("to_wbv", {31'b0, wb_valid}, 1);
        chk("to_wben", {31'b0, wb_en}, 0);
        tick();
        chk("to_err_sticky", {31'b0, mem_err}, 1);
        rst = 1;
        #1;
        chk("to_err_cleared", {31'b0, mem_err}, 0);
        @(negedge clk);
        rst = 0;
`else
        chk("no_timeout_err", {31'b0, mem_err}, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
